hit_window_counter: RTL

//  Consumer of the one-cycle window tick from the slow tick generator. Counts per-channel hit

---
 rtl/hit_window_counter.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hit_window_counter.sv
// Per-channel hit counter over tick-delimited windows. Each accepted tick snapshots the
// counts, which are then streamed out one channel per beat on a valid/ready interface.
module hit_window_counter #(
  parameter int NUM_CH  = 8,
  parameter int COUNT_W = 16,
  parameter int WIN_W   = 16,
  localparam int CH_W   = $clog2(NUM_CH)
) (
  input  logic               clk40M,
  input  logic               rst,
  input  logic [NUM_CH-1:0]  hit,
  input  logic               tick,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [CH_W-1:0]    out_channel,
  output logic [COUNT_W-1:0] out_count,
  output logic [WIN_W-1:0]   out_window,
  output logic               out_last,
  output logic               busy,
  output logic [15:0]        drop_count
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t               state_q, state_d;
  logic [COUNT_W-1:0]   cnt_q    [NUM_CH];
  logic [COUNT_W-1:0]   shadow_q [NUM_CH];
  logic [WIN_W-1:0]     win_q;
  logic [15:0]          drop_q;

  logic                 valid_q, valid_d;
  logic [CH_W-1:0]      channel_q, channel_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [WIN_W-1:0]     window_q, window_d;
  logic                 last_q, last_d;
  logic                 busy_q, busy_d;

  logic                 handshake;
  logic                 last_hs;
  logic                 accept;
  logic [CH_W-1:0]      ch_inc;

  assign handshake = valid_q & out_ready;
  assign last_hs   = handshake & last_q;
  // A tick may start a new snapshot only if the current readout is idle or just finishing.
  assign accept    = tick & ((state_q == IDLE) | last_hs);
  assign ch_inc    = channel_q + 1'b1;

  // Live counters: a tick restarts the window, counting a coincident hit as the first one.
  always_ff @(posedge clk40M) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        cnt_q[i] <= '0;
      end else if (tick) begin
        cnt_q[i] <= hit[i] ? COUNT_W'(1) : '0;
      end else if (hit[i] && (cnt_q[i] != '1)) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk40M) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (rst) begin
        shadow_q[i] <= '0;
      end else if (accept) begin
        shadow_q[i] <= cnt_q[i];
      end
    end
  end

  always_ff @(posedge clk40M) begin
    if (rst) begin
      win_q  <= '0;
      drop_q <= '0;
    end else if (tick) begin
      win_q <= win_q + 1'b1;
      if (!accept && (drop_q != 16'hFFFF)) begin
        drop_q <= drop_q + 1'b1;
      end
    end
  end

  // State and registered outputs.
  always_ff @(posedge clk40M) begin
    if (rst) begin
      state_q   <= IDLE;
      valid_q   <= 1'b0;
      channel_q <= '0;
      count_q   <= '0;
      window_q  <= '0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      valid_q   <= valid_d;
      channel_q <= channel_d;
      count_q   <= count_d;
      window_q  <= window_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = SEND;
      SEND:    if (last_hs && !accept) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Next beat contents; channel 0 of a fresh snapshot comes straight from the live counters.
  always_comb begin
    valid_d   = valid_q;
    channel_d = channel_q;
    count_d   = count_q;
    window_d  = window_q;
    last_d    = last_q;
    busy_d    = (state_d == SEND);
    if (accept) begin
      valid_d   = 1'b1;
      channel_d = '0;
      count_d   = cnt_q[0];
      window_d  = win_q;
      last_d    = 1'b0;
    end else if (handshake) begin
      if (last_q) begin
        valid_d = 1'b0;
        last_d  = 1'b0;
      end else begin
        channel_d = ch_inc;
        count_d   = shadow_q[ch_inc];
        last_d    = (ch_inc == LAST_CH);
      end
    end
  end

  assign out_valid   = valid_q;
  assign out_channel = channel_q;
  assign out_count   = count_q;
  assign out_window  = window_q;
  assign out_last    = last_q;
  assign busy        = busy_q;
  assign drop_count  = drop_q;

endmodule
